// File: rtl/pc_unit.sv
// pc_unit: fetch program counter with next-PC selection.
// Next PC is picked from exception vector, hold, exception return,
// branch/jump redirect, return-address stack pop, or sequential +4.
//
// Ports:
//   clk, reset            clock, asynchronous active-low reset
//   stall                 hold PC/RAS/EPC (overridden by exc_req)
//   redirect_en/_target   taken branch/jump and its destination
//   exc_req, eret         exception entry / exception return
//   call_push, ret_pop    RAS push of pc_plus4 / predicted-return pop
//   pc_out, epc_out       registered fetch PC and saved exception PC
//   pc_plus4              pc_out + 4 (combinational)
//   ras_top/_empty/_full  RAS status (combinational from state)
//   misalign              one-cycle pulse after a misaligned redirect
module pc_unit #(
  parameter int unsigned      WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter logic [31:0]      EXC_VECTOR   = 32'h0000_0180,
  parameter int unsigned      RAS_DEPTH    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             redirect_en,
  input  logic [WIDTH-1:0] redirect_target,
  input  logic             exc_req,
  input  logic             eret,
  input  logic             call_push,
  input  logic             ret_pop,
  output logic [WIDTH-1:0] pc_out,
  output logic [WIDTH-1:0] pc_plus4,
  output logic [WIDTH-1:0] epc_out,
  output logic [WIDTH-1:0] ras_top,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             misalign
);

  localparam int unsigned      PTR_W   = $clog2(RAS_DEPTH);
  localparam int unsigned      CNT_W   = PTR_W + 1;
  localparam logic [WIDTH-1:0] EXC_PC  = WIDTH'(EXC_VECTOR);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RAS_DEPTH);

  logic [WIDTH-1:0] ras_q [RAS_DEPTH];
  logic [PTR_W-1:0] top_q, top_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] pc_d, epc_d;
  logic             mis_d;
  logic             wr_en;
  logic [PTR_W-1:0] wr_idx;
  logic             pop_ok;

  assign pc_plus4  = pc_out + WIDTH'(4);
  assign ras_empty = (cnt_q == '0);
  assign ras_full  = (cnt_q == CNT_MAX);
  assign ras_top   = ras_empty ? '0 : ras_q[top_q];
  assign pop_ok    = ret_pop && !ras_empty;

  // Next-state selection for PC, EPC, RAS pointer/count and misalign.
  always_comb begin
    pc_d   = pc_out;
    epc_d  = epc_out;
    mis_d  = 1'b0;
    top_d  = top_q;
    cnt_d  = cnt_q;
    wr_en  = 1'b0;
    wr_idx = top_q;
    if (exc_req) begin
      pc_d  = EXC_PC;
      epc_d = pc_out;
    end else if (!stall) begin
      // RAS bookkeeping happens even when a higher source wins the PC.
      if (call_push && pop_ok) begin
        wr_en = 1'b1;                       // replace top in place
      end else if (call_push) begin
        wr_en  = 1'b1;
        wr_idx = top_q + PTR_W'(1);         // wraps onto oldest when full
        top_d  = top_q + PTR_W'(1);
        if (!ras_full) cnt_d = cnt_q + CNT_W'(1);
      end else if (pop_ok) begin
        top_d = top_q - PTR_W'(1);
        cnt_d = cnt_q - CNT_W'(1);
      end

      if (eret) begin
        pc_d = epc_out;
      end else if (redirect_en) begin
        pc_d  = {redirect_target[WIDTH-1:2], 2'b00};
        mis_d = |redirect_target[1:0];
      end else if (pop_ok) begin
        pc_d = ras_top;
      end else begin
        pc_d = pc_plus4;
      end
    end
  end

  // PC, EPC, pointer and flag registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_out   <= RESET_VECTOR;
      epc_out  <= '0;
      top_q    <= '0;
      cnt_q    <= '0;
      misalign <= 1'b0;
    end else begin
      pc_out   <= pc_d;
      epc_out  <= epc_d;
      top_q    <= top_d;
      cnt_q    <= cnt_d;
      misalign <= mis_d;
    end
  end

  // Return-address stack storage.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(RAS_DEPTH); i++) ras_q[i] <= '0;
    end else if (wr_en) begin
      ras_q[wr_idx] <= pc_plus4;
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
// Directed testbench for pc_unit: a 32-bit instance (RESET_VECTOR 0x400)
// and an 8-bit instance (RESET_VECTOR 0x40) for wrap/truncation cases.
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, redirect_en, exc_req, eret, call_push, ret_pop;
  logic [31:0] redirect_target;
  logic [31:0] pc_out, pc_plus4, epc_out, ras_top;
  logic        ras_empty, ras_full, misalign;

  logic        reset8;
  logic        stall8, redirect_en8, exc_req8, eret8, call_push8, ret_pop8;
  logic [7:0]  redirect_target8;
  logic [7:0]  pc_out8, pc_plus48, epc_out8, ras_top8;
  logic        ras_empty8, ras_full8, misalign8;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  pc_unit #(.WIDTH(32), .RESET_VECTOR(32'h400), .EXC_VECTOR(32'h180), .RAS_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .stall(stall), .redirect_en(redirect_en),
    .redirect_target(redirect_target), .exc_req(exc_req), .eret(eret),
    .call_push(call_push), .ret_pop(ret_pop), .pc_out(pc_out), .pc_plus4(pc_plus4),
    .epc_out(epc_out), .ras_top(ras_top), .ras_empty(ras_empty), .ras_full(ras_full),
    .misalign(misalign)
  );

  pc_unit #(.WIDTH(8), .RESET_VECTOR(8'h40), .EXC_VECTOR(32'h180), .RAS_DEPTH(2)) dut8 (
    .clk(clk), .reset(reset8), .stall(stall8), .redirect_en(redirect_en8),
    .redirect_target(redirect_target8), .exc_req(exc_req8), .eret(eret8),
    .call_push(call_push8), .ret_pop(ret_pop8), .pc_out(pc_out8), .pc_plus4(pc_plus48),
    .epc_out(epc_out8), .ras_top(ras_top8), .ras_empty(ras_empty8), .ras_full(ras_full8),
    .misalign(misalign8)
  );

  task automatic clear_inputs();
    stall = 0; redirect_en = 0; redirect_target = '0; exc_req = 0;
    eret = 0; call_push = 0; ret_pop = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 0; reset8 = 0;
    clear_inputs();
    stall8 = 0; redirect_en8 = 0; redirect_target8 = '0; exc_req8 = 0;
    eret8 = 0; call_push8 = 0; ret_pop8 = 0;
    #12;
    vectors++; if (pc_out !== 32'h400) begin errors++; $display("FAIL reset_pc got %h want %h", pc_out, 32'h400); end
    vectors++; if (epc_out !== 32'h0) begin errors++; $display("FAIL reset_epc got %h want 0", epc_out); end
    vectors++; if (ras_empty !== 1'b1 || ras_full !== 1'b0) begin errors++; $display("FAIL reset_ras got e=%b f=%b want e=1 f=0", ras_empty, ras_full); end
    vectors++; if (ras_top !== 32'h0) begin errors++; $display("FAIL reset_ras_top got %h want 0", ras_top); end
    vectors++; if (misalign !== 1'b0) begin errors++; $display("FAIL reset_misalign got %b want 0", misalign); end
    @(negedge clk);
    reset = 1; reset8 = 1;
    for (int i = 1; i <= 3; i++) begin
      step();
      vectors++;
      if (pc_out !== 32'h400 + 32'(4 * i)) begin
        errors++; $display("FAIL seq_pc%0d got %h want %h", i, pc_out, 32'h400 + 32'(4 * i));
      end
    end
    vectors++; if (pc_plus4 !== 32'h410) begin errors++; $display("FAIL seq_plus4 got %h want 410", pc_plus4); end
  endtask

  task automatic test_redirect_misalign();
    clear_inputs(); redirect_en = 1; redirect_target = 32'h1000;
    step();
    vectors++; if (pc_out !== 32'h1000 || misalign !== 1'b0) begin errors++; $display("FAIL redir_aligned got %h/%b want 1000/0", pc_out, misalign); end
    redirect_target = 32'h2003;
    step();
    vectors++; if (pc_out !== 32'h2000 || misalign !== 1'b1) begin errors++; $display("FAIL redir_misaligned got %h/%b want 2000/1", pc_out, misalign); end
    clear_inputs(); stall = 1;
    step();
    vectors++; if (pc_out !== 32'h2000 || misalign !== 1'b0) begin errors++; $display("FAIL stall_hold got %h/%b want 2000/0", pc_out, misalign); end
  endtask

  task automatic test_exception();
    clear_inputs(); redirect_en = 1; redirect_target = 32'h50;
    step();
    clear_inputs(); exc_req = 1; stall = 1; eret = 1;
    step();
    vectors++; if (pc_out !== 32'h180) begin errors++; $display("FAIL exc_pc got %h want 180", pc_out); end
    vectors++; if (epc_out !== 32'h50) begin errors++; $display("FAIL exc_epc got %h want 50", epc_out); end
    clear_inputs(); eret = 1;
    step();
    vectors++; if (pc_out !== 32'h50 || epc_out !== 32'h50) begin errors++; $display("FAIL eret got pc %h epc %h want 50/50", pc_out, epc_out); end
  endtask

  task automatic test_ras();
    logic [31:0] pops [4];
    pops[0] = 32'h54; pops[1] = 32'h44; pops[2] = 32'h34; pops[3] = 32'h24;
    clear_inputs(); redirect_en = 1; redirect_target = 32'h10;
    step();
    for (int i = 0; i < 5; i++) begin
      clear_inputs(); call_push = 1; redirect_en = 1;
      redirect_target = (i == 4) ? 32'h100 : 32'(16 * (i + 2));
      step();
      if (i == 3) begin
        vectors++; if (ras_full !== 1'b1 || ras_top !== 32'h44) begin errors++; $display("FAIL ras_fill4 got f=%b top=%h want 1/44", ras_full, ras_top); end
      end
    end
    vectors++; if (ras_full !== 1'b1 || ras_top !== 32'h54) begin errors++; $display("FAIL ras_wrap got f=%b top=%h want 1/54", ras_full, ras_top); end
    vectors++; if (pc_out !== 32'h100) begin errors++; $display("FAIL ras_push_redir got %h want 100", pc_out); end
    for (int i = 0; i < 4; i++) begin
      clear_inputs(); ret_pop = 1;
      step();
      vectors++; if (pc_out !== pops[i]) begin errors++; $display("FAIL ras_pop%0d got %h want %h", i, pc_out, pops[i]); end
    end
    vectors++; if (ras_empty !== 1'b1 || ras_top !== 32'h0) begin errors++; $display("FAIL ras_drained got e=%b top=%h want 1/0", ras_empty, ras_top); end
    step();
    vectors++; if (pc_out !== 32'h28) begin errors++; $display("FAIL ras_pop_empty got %h want 28", pc_out); end
  endtask

  task automatic test_push_pop();
    clear_inputs(); redirect_en = 1; redirect_target = 32'h84;
    step();
    call_push = 1; redirect_target = 32'h200;
    step();
    vectors++; if (pc_out !== 32'h200 || ras_top !== 32'h88) begin errors++; $display("FAIL pp_setup got pc %h top %h want 200/88", pc_out, ras_top); end
    clear_inputs(); call_push = 1; ret_pop = 1;
    step();
    vectors++; if (pc_out !== 32'h88 || ras_top !== 32'h204) begin errors++; $display("FAIL pp_swap got pc %h top %h want 88/204", pc_out, ras_top); end
    vectors++; if (ras_empty !== 1'b0 || ras_full !== 1'b0) begin errors++; $display("FAIL pp_count got e=%b f=%b want 0/0", ras_empty, ras_full); end
    clear_inputs(); ret_pop = 1;
    step();
    vectors++; if (pc_out !== 32'h204 || ras_empty !== 1'b1) begin errors++; $display("FAIL pp_pop got pc %h e=%b want 204/1", pc_out, ras_empty); end
  endtask

  task automatic test_back_to_back();
    clear_inputs(); call_push = 1;
    step();
    vectors++; if (pc_out !== 32'h208 || ras_top !== 32'h208) begin errors++; $display("FAIL b2b_push got pc %h top %h want 208/208", pc_out, ras_top); end
    clear_inputs(); stall = 1; call_push = 1; ret_pop = 1; redirect_en = 1; redirect_target = 32'h301;
    step();
    vectors++; if (pc_out !== 32'h208 || ras_top !== 32'h208 || misalign !== 1'b0) begin errors++; $display("FAIL b2b_stall got pc %h top %h mis %b want 208/208/0", pc_out, ras_top, misalign); end
    clear_inputs(); ret_pop = 1; redirect_en = 1; redirect_target = 32'h400;
    step();
    vectors++; if (pc_out !== 32'h400 || ras_empty !== 1'b1) begin errors++; $display("FAIL b2b_pop_discard got pc %h e=%b want 400/1", pc_out, ras_empty); end
  endtask

  task automatic test_wrap8();
    redirect_en8 = 1; redirect_target8 = 8'hFC;
    step();
    vectors++; if (pc_out8 !== 8'hFC || pc_plus48 !== 8'h00) begin errors++; $display("FAIL w8_load got %h/%h want fc/00", pc_out8, pc_plus48); end
    redirect_en8 = 0;
    step();
    vectors++; if (pc_out8 !== 8'h00) begin errors++; $display("FAIL w8_wrap got %h want 00", pc_out8); end
    exc_req8 = 1;
    step();
    exc_req8 = 0;
    vectors++; if (pc_out8 !== 8'h80 || epc_out8 !== 8'h00) begin errors++; $display("FAIL w8_exc got %h/%h want 80/00", pc_out8, epc_out8); end
    step();
    #3;
    reset8 = 0;
    #1;
    vectors++; if (pc_out8 !== 8'h40 || epc_out8 !== 8'h00) begin errors++; $display("FAIL w8_async_reset got %h/%h want 40/00", pc_out8, epc_out8); end
    @(negedge clk);
    reset8 = 1;
  endtask

  initial begin
    test_reset();
    test_redirect_misalign();
    test_exception();
    test_ras();
    test_push_pop();
    test_back_to_back();
    test_wrap8();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
